// File: rtl/baby_kyber_pkg.sv
// Shared types, constants and mod-17 arithmetic for the Baby Kyber decryption engine.
package baby_kyber_pkg;
  localparam int N = 4;
  localparam int K = 2;
  localparam int Q = 17;

  typedef logic [4:0]         coef_t;
  typedef logic signed [31:0] word_t;
  typedef word_t [N-1:0]      poly_t;
  typedef poly_t [K-1:0]      vec_t;

  localparam coef_t DEC_LO = 5'd5;
  localparam coef_t DEC_HI = 5'd12;

  typedef enum logic [2:0] {
    S_IDLE, S_REDUCE, S_MAC, S_DECODE, S_DONE
  } state_t;

  // (a +/- b) mod Q for a in [0,Q-1], b <= 256; adding 16*Q keeps the difference non-negative.
  function automatic coef_t mod17_addsub(input logic [9:0] a, input logic [9:0] b,
                                         input logic sub);
    logic [10:0] x;
    x = sub ? (11'(a) + 11'(Q * 16) - 11'(b)) : (11'(a) + 11'(b));
    return coef_t'(x % 11'(Q));
  endfunction
endpackage

// File: rtl/baby_kyber_if.sv
// Operand/result handshake bundle between a client and the decryption engine.
interface baby_kyber_if;
  import baby_kyber_pkg::*;
  logic       in_valid;
  logic       in_ready;
  vec_t       secretkey;
  vec_t       u;
  poly_t      v;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] msg;
  logic       busy;

  modport master (output in_valid, secretkey, u, v, out_ready,
                  input  in_ready, out_valid, msg, busy);
  modport slave  (input  in_valid, secretkey, u, v, out_ready,
                  output in_ready, out_valid, msg, busy);
endinterface

// File: rtl/baby_kyber_decrypt_mod17_reduce.sv
// Combinational signed reduction of a raw 32-bit coefficient into [0,16].
module mod17_reduce
  import baby_kyber_pkg::*;
(
  input  word_t i_x,
  output coef_t o_r
);
  word_t w_m;
  word_t w_adj;
  assign w_m   = i_x % 32'sd17;
  assign w_adj = (w_m < 0) ? w_m + 32'sd17 : w_m;
  assign o_r   = w_adj[4:0];
endmodule

// File: rtl/baby_kyber_decrypt.sv
// Baby Kyber decryption: w = v - s^T u in Z17[x]/(x^4+1) with one serial MAC, then 1-bit decode.
module baby_kyber_decrypt
  import baby_kyber_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  baby_kyber_if.slave bus
);
  state_t           r_state, w_next;
  vec_t             r_s, r_u;
  poly_t            r_v;
  coef_t [N-1:0]    r_acc;
  logic [4:0]       r_cnt;
  logic [3:0]       r_msg;

  coef_t [K-1:0][N-1:0] w_sr, w_ur;
  coef_t [N-1:0]        w_vr, w_w;
  logic  [N-1:0]        w_msg;

  for (genvar gk = 0; gk < K; gk++) begin : g_vec
    for (genvar gi = 0; gi < N; gi++) begin : g_coef
      mod17_reduce u_rs (.i_x(r_s[gk][gi]), .o_r(w_sr[gk][gi]));
      mod17_reduce u_ru (.i_x(r_u[gk][gi]), .o_r(w_ur[gk][gi]));
    end
  end
  for (genvar gi = 0; gi < N; gi++) begin : g_v
    mod17_reduce u_rv (.i_x(r_v[gi]), .o_r(w_vr[gi]));
    assign w_w[gi]   = mod17_addsub(10'(r_v[gi][4:0]), 10'(r_acc[gi]), 1'b1);
    assign w_msg[gi] = (w_w[gi] >= DEC_LO) && (w_w[gi] <= DEC_HI);
  end

  // Counter layout {k,i,j}; an i+j carry means the term wrapped past x^4 and is subtracted.
  logic       w_k;
  logic [1:0] w_i, w_j;
  logic [2:0] w_sum;
  logic [9:0] w_prod;
  coef_t      w_acc_nxt;
  assign {w_k, w_i, w_j} = r_cnt;
  assign w_sum     = {1'b0, w_i} + {1'b0, w_j};
  assign w_prod    = 10'(r_s[w_k][w_i][4:0]) * 10'(r_u[w_k][w_j][4:0]);
  assign w_acc_nxt = mod17_addsub(10'(r_acc[w_sum[1:0]]), w_prod, w_sum[2]);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.msg       = r_msg;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) w_next = S_REDUCE;
      end
      S_REDUCE: w_next = S_MAC;
      S_MAC:    if (r_cnt == 5'd31) w_next = S_DECODE;
      S_DECODE: w_next = S_DONE;
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s   <= '0;
      r_u   <= '0;
      r_v   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_msg <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_s <= bus.secretkey;
          r_u <= bus.u;
          r_v <= bus.v;
        end
        S_REDUCE: begin
          for (int k = 0; k < K; k++)
            for (int i = 0; i < N; i++) begin
              r_s[k][i] <= 32'(w_sr[k][i]);
              r_u[k][i] <= 32'(w_ur[k][i]);
            end
          for (int i = 0; i < N; i++) r_v[i] <= 32'(w_vr[i]);
          r_acc <= '0;
          r_cnt <= '0;
        end
        S_MAC: begin
          r_acc[w_sum[1:0]] <= w_acc_nxt;
          r_cnt             <= r_cnt + 5'd1;
        end
        S_DECODE: r_msg <= w_msg;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_baby_kyber_decrypt.sv
// Directed + random bench for baby_kyber_decrypt with an expected-msg scoreboard queue.
module tb_baby_kyber_decrypt;
  import baby_kyber_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  baby_kyber_if bus();
  baby_kyber_decrypt dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;
  logic [3:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int red(input int x);
    int m;
    m = x % 17;
    return (m < 0) ? m + 17 : m;
  endfunction

  // Reference: schoolbook negacyclic product on fully reduced integers, then threshold decode.
  function automatic logic [3:0] model(input vec_t s, input vec_t uu, input poly_t vv);
    int acc[4];
    int w;
    logic [3:0] m;
    for (int i = 0; i < 4; i++) acc[i] = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (i + j < 4) acc[i+j]   += red(int'(s[k][i])) * red(int'(uu[k][j]));
          else           acc[i+j-4] -= red(int'(s[k][i])) * red(int'(uu[k][j]));
    for (int i = 0; i < 4; i++) begin
      w = red(red(int'(vv[i])) - red(acc[i]));
      m[i] = (w >= 5) && (w <= 12);
    end
    return m;
  endfunction

  task automatic scramble();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        bus.secretkey[k][i] = $urandom;
        bus.u[k][i]         = $urandom;
      end
    for (int i = 0; i < 4; i++) bus.v[i] = $urandom;
  endtask

  // Called just after a negedge with the engine idle; returns at the negedge after the accept edge.
  task automatic issue(input vec_t s, input vec_t uu, input poly_t vv, input logic [3:0] e);
    bus.secretkey = s;
    bus.u         = uu;
    bus.v         = vv;
    bus.in_valid  = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    t_acc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble();
  endtask

  task automatic finish_op(input string tag, input int hold);
    int n = 1;
    int bad = 0;
    logic [3:0] m0;
    logic [3:0] e;
    while (!bus.out_valid && n < 100) begin
      if (!bus.busy || bus.in_ready) bad++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 35);
    chk({tag, "_busy"}, bad, 0);
    if (sb.size() > 0) e = sb.pop_front();
    else e = 4'hx;
    chk({tag, "_msg"}, bus.msg, e);
    if (hold > 0) begin
      m0 = bus.msg;
      bad = 0;
      for (int c = 0; c < hold; c++) begin
        bus.in_valid = c[0];
        @(negedge clk);
        if (bus.msg !== m0 || bus.in_ready || !bus.out_valid || !bus.busy) bad++;
      end
      chk({tag, "_hold"}, bad, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_idle"}, {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
  endtask

  vec_t  s, uu;
  poly_t vv;
  int    t_first;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_msg", bus.msg, 0);

    s = '0; uu = '0; vv = '0;
    s[0][0] = 1; vv[1] = 9; vv[2] = 8; vv[3] = 13;
    issue(s, uu, vv, 4'b0110);
    finish_op("basic", 0);

    s = '0; uu = '0; vv = '0;
    s[0][1] = 1; uu[0][3] = 1; vv[0] = 8;
    issue(s, uu, vv, 4'b0001);
    finish_op("wrap", 0);

    s = '0; uu = '0; vv = '0;
    s[0][0] = 32'hFFFFFFFF; uu[0][0] = 4; vv[0] = 1;
    issue(s, uu, vv, 4'b0001);
    finish_op("neg_a", 0);
    vv[0] = 30;
    issue(s, uu, vv, 4'b0000);
    finish_op("neg_b", 10);

    s = '0; uu = '0;
    vv[0] = 4; vv[1] = 5; vv[2] = 12; vv[3] = 13;
    issue(s, uu, vv, 4'b0110);
    t_first = t_acc;
    finish_op("thr_a", 0);
    vv[0] = 0; vv[1] = 16; vv[2] = -8; vv[3] = 8;
    issue(s, uu, vv, 4'b1100);
    chk("issue_interval", t_acc - t_first, 36);
    finish_op("thr_b", 0);

    // Abort mid-MAC: after the accept edge, 16 more edges leave the counter at 15.
    s = '0; uu = '0; vv = '0;
    s[0][0] = 3; uu[0][0] = 5; uu[1][2] = 7; s[1][1] = 2;
    issue(s, uu, vv, 4'b0000);
    repeat (16) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb.pop_back());
    chk("abort_idle", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    chk("abort_msg", bus.msg, 0);
    issue(s, uu, vv, model(s, uu, vv));
    finish_op("post_rst", 0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 4; i++) begin
          s[k][i]  = $urandom;
          uu[k][i] = $urandom;
        end
      for (int i = 0; i < 4; i++) vv[i] = $urandom;
      issue(s, uu, vv, model(s, uu, vv));
      finish_op("rand", 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/baby_kyber_decrypt.md
# baby_kyber_decrypt

Decryption engine of the Baby Kyber accelerator (n=4, k=2, q=17). It accepts a secret-key vector s and a ciphertext (u, v) through a valid/ready handshake. It computes w = v − sᵀ·u in Z17[x]/(x⁴+1) using one serial multiply-accumulate unit, then decodes each coefficient of w into one message bit. It consumes the secret key produced by key generation and the ciphertext produced by the encryption path.

## Interface
- N, 4, polynomial degree (coefficients per polynomial)
- K, 2, module rank (polynomials per vector)
- Q, 17, coefficient modulus
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  s/u/v operands valid
- in_ready  out  1  block can accept operands; equals (state == IDLE)
- secretkey  in  32 × [1:0][3:0]  s, signed two's-complement coefficients
- u  in  32 × [1:0][3:0]  ciphertext vector u, signed
- v  in  32 × [3:0]  ciphertext polynomial v, signed
- out_valid  out  1  msg valid; held until accepted
- out_ready  in  1  downstream accepts msg
- msg  out  4  decoded message; msg[i] comes from coefficient w[i]
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE → REDUCE → MAC → DECODE → DONE → IDLE.
- IDLE
  - in_ready=1.
  - On in_valid, register all 20 operand words and go to REDUCE.
- REDUCE (1 cycle)
  - Reduce every registered coefficient to [0,16] by signed modulo: x<0 → ((x % 17) + 17) % 17.
  - Example: 32'hFFFFFFFF → 16.
  - Clear accumulators acc[0..3] to 0.
- MAC (32 cycles)
  - Counter {k,i,j} runs over k∈{0,1}, i∈{0..3}, j∈{0..3}; j is fastest, k is slowest.
  - Each cycle: p = s[k][i]·u[k][j] (≤256, 9 bits), t = (i+j) mod 4.
  - If i+j < 4: acc[t] ← (acc[t] + p) mod 17. Otherwise acc[t] ← (acc[t] − p) mod 17, because x⁴ = −1.
  - All accumulator values stay in [0,16].
- DECODE (1 cycle)
  - w[i] = (v[i] − acc[i]) mod 17, in [0,16].
  - msg[i] = 1 iff 5 ≤ w[i] ≤ 12, i.e. round(2·w/17) mod 2.
  - Register msg.
- DONE
  - out_valid=1 and msg held stable.
  - On out_ready, go to IDLE and drop out_valid.
- in_valid is ignored outside IDLE. Operands may change freely after the accept cycle.

## Timing
- Reset values (rst_n low at a clock edge): state=IDLE, in_ready=1, out_valid=0, busy=0, msg=0, accumulators, counter and operand registers all 0.
- Reset mid-operation (any state) aborts the computation. The next cycle is IDLE with the values above, and no partial msg is ever presented.
- Latency: with the accept edge at T, REDUCE runs at T+1, MAC at T+2..T+33 and DECODE at T+34. out_valid is high from T+35.
- Minimum issue interval is 36 cycles: the out_ready handshake at T+35 returns to IDLE, and the next accept can happen at T+36.
- Output back-pressure: out_ready low holds DONE indefinitely with msg constant. in_ready stays 0 during that time.
- in_ready and out_valid are never high in the same cycle.
- The MAC counter wraps from {1,3,3} to DECODE. It never overruns into a 33rd cycle.

## Structure
- Package baby_kyber_pkg holds:
  - constants N, K, Q and the decode thresholds (5, 12);
  - typedef coef_t (5-bit unsigned, reduced coefficient);
  - typedef word_t (signed 32-bit raw coefficient);
  - the decrypt state enum.
- Sub-module mod17_reduce: combinational, signed 32-bit in, coef_t out. It is instantiated once per operand word in REDUCE. Add/subtract-mod in MAC and DECODE use a shared package function on 10-bit values.

## Test plan
- s0=[1,0,0,0], s1=0, u=0, v=[0,9,8,13] → msg=4'b0110 at T+35; busy high T+1..T+35.
- Wrap sign: s0=[0,1,0,0], u0=[0,0,0,1], s1=u1=0, v=[8,0,0,0] → acc=[16,0,0,0], w0=9, msg=4'b0001.
- Negative input: s0=[−1,0,0,0] (32'hFFFFFFFF), u0=[4,0,0,0], v=[1,0,0,0], rest 0 → acc0=13, w0=5, msg=4'b0001. Repeat with v=[30,0,0,0] (reduces to 13) → w0=0, msg=4'b0000.
- Thresholds: s=u=0, v=[4,5,12,13] → msg=4'b0110; v=[0,16,−8,8] → msg=4'b1100.
- Handshake: out_ready held low 10 cycles → msg stable and in_ready=0 throughout, with in_valid pulsed during that time ignored. On out_ready, next accept at +1 cycle; back-to-back issue interval is 36.
- Reset at MAC cycle 15 → next cycle IDLE, out_valid=0, msg=0. A fresh operation then gives the correct result with no residue in the accumulators.
